// File: rtl/gate_sweep_controller.sv
// Walks a 2-input gate under test through its truth table, holding each input
// vector for SETTLE cycles, and compares the captured outputs against EXPECT.
module gate_sweep_controller #(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  EXPECT = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gate_y,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]         r_result;
    logic [3:0]         w_result_nxt;
    logic               r_pass;
    logic               w_pass_nxt;
    logic               r_gate_a;
    logic               r_gate_b;
    logic               r_busy;
    logic               r_done;
    logic               w_gate_a_nxt;
    logic               w_gate_b_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_pass   <= 1'b0;
            r_gate_a <= 1'b0;
            r_gate_b <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_pass   <= w_pass_nxt;
            r_gate_a <= w_gate_a_nxt;
            r_gate_b <= w_gate_b_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next state; outputs are derived from the next state so they register in step
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_pass_nxt   = r_pass;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_DRIVE;
                    w_idx_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                    w_pass_nxt   = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_cnt_nxt             = '0;
                    w_result_nxt[r_idx]   = gate_y;
                    if (r_idx == LP_IDX_LAST) begin
                        w_state_nxt = ST_DONE;
                        w_pass_nxt  = ({gate_y, r_result[2:0]} == EXPECT);
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt   = (w_state_nxt == ST_DRIVE);
        w_done_nxt   = (w_state_nxt == ST_DONE);
        w_gate_a_nxt = w_busy_nxt & w_idx_nxt[1];
        w_gate_b_nxt = w_busy_nxt & w_idx_nxt[0];
    end

    assign gate_a = r_gate_a;
    assign gate_b = r_gate_b;
    assign busy   = r_busy;
    assign done   = r_done;
    assign pass   = r_pass;
    assign result = r_result;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Directed bench for gate_sweep_controller: one instance at SETTLE=2 and one at
// SETTLE=1, each driving a behavioural gate whose function the bench selects.
module tb_gate_sweep_controller;

    localparam int unsigned GM_NOR   = 0;
    localparam int unsigned GM_AND   = 1;
    localparam int unsigned GM_STUCK = 2;

    logic       clk;
    logic       rst;
    logic       start2;
    logic       start1;
    int unsigned gate_mode;

    logic       y2, a2, b2, busy2, done2, pass2;
    logic [3:0] result2;
    logic       y1, a1, b1, busy1, done1, pass1;
    logic [3:0] result1;

    int n_checks;
    int n_errors;

    gate_sweep_controller #(.SETTLE(2), .EXPECT(4'b0001)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .gate_y(y2),
        .gate_a(a2), .gate_b(b2), .busy(busy2), .done(done2),
        .pass(pass2), .result(result2)
    );

    gate_sweep_controller #(.SETTLE(1), .EXPECT(4'b0001)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_y(y1),
        .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1),
        .pass(pass1), .result(result1)
    );

    function automatic logic gate_f(input int unsigned mode, input logic a, input logic b);
        case (mode)
            GM_AND:   return a & b;
            GM_STUCK: return 1'b1;
            default:  return ~(a | b);
        endcase
    endfunction

    assign y2 = gate_f(gate_mode, a2, b2);
    assign y1 = gate_f(gate_mode, a1, b1);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the SETTLE=2 instance; returns just after E0
    task automatic pulse_start2();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
    endtask

    initial begin
        int dcount;
        clk       = 1'b0;
        rst       = 1'b1;
        start2    = 1'b0;
        start1    = 1'b0;
        gate_mode = GM_NOR;
        n_checks  = 0;
        n_errors  = 0;

        #1;
        check("rst_busy",   32'(busy2),   32'd0);
        check("rst_done",   32'(done2),   32'd0);
        check("rst_pass",   32'(pass2),   32'd0);
        check("rst_ab",     32'({a2, b2}), 32'd0);
        check("rst_result", 32'(result2), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // NOR sweep at SETTLE=2
        pulse_start2();
        for (int k = 0; k < 8; k++) begin
            check("nor_busy", 32'(busy2), 32'd1);
            check("nor_ab",   32'({a2, b2}), 32'(k / 2));
            check("nor_done_lo", 32'(done2), 32'd0);
            step();
        end
        check("nor_done",   32'(done2),   32'd1);
        check("nor_busy_end", 32'(busy2), 32'd0);
        check("nor_ab_end", 32'({a2, b2}), 32'd0);
        check("nor_result", 32'(result2), 32'h1);
        check("nor_pass",   32'(pass2),   32'd1);
        step();
        check("nor_done_fall", 32'(done2), 32'd0);
        check("nor_result_hold", 32'(result2), 32'h1);
        step();

        // AND gate against the NOR expectation
        gate_mode = GM_AND;
        pulse_start2();
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done2) dcount++;
            if (k == 7) begin
                check("and_result", 32'(result2), 32'h8);
                check("and_pass",   32'(pass2),   32'd0);
                check("and_done",   32'(done2),   32'd1);
            end
        end
        check("and_done_count", 32'(dcount), 32'd1);

        // SETTLE=1 with start held high for 20 cycles
        gate_mode = GM_NOR;
        start1 = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            check("s1_done", 32'(done1), 32'((k == 4) || (k == 10) || (k == 16)));
            check("s1_busy", 32'(busy1), 32'((k % 6) < 4));
            if (k % 6 < 4)
                check("s1_ab", 32'({a1, b1}), 32'(k % 6));
            if (done1)
                check("s1_pass", 32'(pass1), 32'd1);
            if (k == 19) start1 = 1'b0;
            step();
        end
        for (int k = 0; k < 4; k++) step();
        check("s1_idle_busy", 32'(busy1), 32'd0);
        check("s1_final_result", 32'(result1), 32'h1);

        // Mid-sweep start is ignored
        pulse_start2();
        dcount = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) start2 = 1'b1;
            step();
            if (k == 3) start2 = 1'b0;
            if (done2) dcount++;
            if (k == 8) check("mid_done_at8", 32'(done2), 32'd1);
            if (k == 10) check("mid_no_resweep", 32'(busy2), 32'd0);
        end
        check("mid_done_count", 32'(dcount), 32'd1);

        // Asynchronous reset mid-sweep
        pulse_start2();
        for (int k = 1; k <= 5; k++) step();
        check("pre_rst_busy", 32'(busy2), 32'd1);
        check("pre_rst_ab",   32'({a2, b2}), 32'd2);
        check("pre_rst_result", 32'(result2), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_busy",   32'(busy2),   32'd0);
        check("arst_done",   32'(done2),   32'd0);
        check("arst_pass",   32'(pass2),   32'd0);
        check("arst_ab",     32'({a2, b2}), 32'd0);
        check("arst_result", 32'(result2), 32'h0);
        step();
        rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done2 || busy2) dcount++;
        end
        check("post_rst_quiet", 32'(dcount), 32'd0);
        pulse_start2();
        for (int k = 1; k <= 8; k++) step();
        check("post_rst_done",   32'(done2),   32'd1);
        check("post_rst_result", 32'(result2), 32'h1);
        check("post_rst_pass",   32'(pass2),   32'd1);
        step();

        // Gate output stuck at 1
        gate_mode = GM_STUCK;
        pulse_start2();
        for (int k = 1; k <= 8; k++) step();
        check("stuck_result", 32'(result2), 32'hf);
        check("stuck_pass",   32'(pass2),   32'd0);
        for (int k = 0; k < 5; k++) step();
        check("stuck_hold", 32'(result2), 32'hf);
        gate_mode = GM_NOR;
        pulse_start2();
        check("stuck_clear_result", 32'(result2), 32'h0);
        check("stuck_clear_pass",   32'(pass2),   32'd0);
        for (int k = 1; k <= 10; k++) step();
        check("final_result", 32'(result2), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
